// File: rtl/avalon_ram_pkg.sv
// Shared types and constants for the wait-state Avalon RAM.
package avalon_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } ram_state_t;

    // x^8+x^6+x^5+x^4+1 as feedback taps on bits 7,5,4,3 of a left shifter
    localparam logic [7:0]  LFSR_SEED      = 8'hA5;
    localparam logic [7:0]  LFSR_TAPS      = 8'hB8;
    localparam logic [31:0] OOR_READ_VALUE = 32'h0000_0000;

endpackage

// File: rtl/ram_lfsr8.sv
// 8-bit Fibonacci LFSR that steps once per advance strobe; used for random wait counts.
module ram_lfsr8
    import avalon_ram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= {value[6:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with programmable wait states and a preload port.
// Define RAM_RANDOM_WAIT_EN to draw each request's wait count from an LFSR.
//
//   state | meaning
//   IDLE  | no access in flight; accepts read/write
//   WAIT  | counting down wait states; drop of request aborts
//   ACK   | waitrequest low; write commits / readdata valid
module avalon_wait_ram
    import avalon_ram_pkg::*;
#(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int         DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    logic [31:0] mem [DEPTH];

    ram_state_t  state;
    logic [3:0]  cnt;
    logic [29:0] lat_word;
    logic [31:0] lat_data;
    logic [3:0]  lat_be;
    logic        lat_write;

    logic        request;
    logic        accept;
    logic [3:0]  wait_cnt;
    logic [29:0] cur_word;
    logic [29:0] cur_off;
    logic        cur_hit;
    logic        cur_write;
    logic [29:0] lat_off;
    logic        lat_hit;
    logic [29:0] load_off;
    logic        load_hit;
    logic [31:0] rd_value;
    logic        unused_bits;

    assign unused_bits = ^{address[1:0], load_addr[1:0]};

    assign request = read | write;
    assign accept  = (state == IDLE) && request;

    // In IDLE the incoming address is used so a zero-wait access can go straight to ACK
    assign cur_word  = (state == IDLE) ? address[31:2] : lat_word;
    assign cur_write = (state == IDLE) ? write : lat_write;
    assign cur_off   = cur_word - BASE_WORD;
    assign cur_hit   = (cur_word >= BASE_WORD) && (cur_off[29:DEPTH_LOG2] == '0);
    assign rd_value  = cur_hit ? mem[cur_off[DEPTH_LOG2-1:0]] : OOR_READ_VALUE;

    assign lat_off   = lat_word - BASE_WORD;
    assign lat_hit   = (lat_word >= BASE_WORD) && (lat_off[29:DEPTH_LOG2] == '0);

    assign load_off  = load_addr[31:2] - BASE_WORD;
    assign load_hit  = (load_addr[31:2] >= BASE_WORD) && (load_off[29:DEPTH_LOG2] == '0);

`ifdef RAM_RANDOM_WAIT_EN
    logic [7:0] lfsr_value;

    ram_lfsr8 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .value   (lfsr_value)
    );

    assign wait_cnt = 4'(lfsr_value % 8'(WAIT_CYCLES + 1));
`else
    assign wait_cnt = 4'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            waitrequest <= 1'b1;
            readdata    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_word  <= address[31:2];
                        lat_data  <= writedata;
                        lat_be    <= byteenable;
                        lat_write <= write;
                        if (wait_cnt == 4'd0) begin
                            cnt         <= 4'd0;
                            state       <= ACK;
                            waitrequest <= 1'b0;
                            if (!cur_write) readdata <= rd_value;
                        end else begin
                            cnt   <= wait_cnt - 4'd1;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!request) begin
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        state       <= ACK;
                        waitrequest <= 1'b0;
                        if (!cur_write) readdata <= rd_value;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                end
            endcase
        end
    end

    // Preload is written last so it overrides a same-edge ACK write to the same word
    always_ff @(posedge clk) begin
        if (!reset && state == ACK && lat_write && lat_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_be[b]) mem[lat_off[DEPTH_LOG2-1:0]][8*b +: 8] <= lat_data[8*b +: 8];
            end
        end
        if (load_en && load_hit) begin
            mem[load_off[DEPTH_LOG2-1:0]] <= load_data;
        end
    end

endmodule
